// File: rtl/sensor_debouncer.sv
// Per-channel input conditioner: 2-flop synchroniser followed by a counter-based
// debouncer that emits registered clean levels and one-cycle rise/fall pulses.
module sensor_debouncer #(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 1000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] clean,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed,
    output logic             busy
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] sync2_r;
    logic [WIDTH-1:0] clean_r;
    logic [WIDTH-1:0] rise_r;
    logic [WIDTH-1:0] fall_r;
    logic             changed_r;
    logic [CNT_W-1:0] cnt_r      [WIDTH];

    logic [CNT_W-1:0] cnt_next_s [WIDTH];
    logic [WIDTH-1:0] clean_next_s;
    logic [WIDTH-1:0] rise_next_s;
    logic [WIDTH-1:0] fall_next_s;
    logic             busy_s;

    // Next-state per channel; a zero count is the STABLE state, anything else is COUNTING.
    // With STABLE_CYCLES==1 the last count is zero, so a mismatch is accepted at once.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next_s[i]   = CNT_ZERO;
            clean_next_s[i] = clean_r[i];
            rise_next_s[i]  = 1'b0;
            fall_next_s[i]  = 1'b0;
            if (!enable) begin
                cnt_next_s[i] = CNT_ZERO;
            end else if (sync2_r[i] == clean_r[i]) begin
                cnt_next_s[i] = CNT_ZERO;
            end else if (cnt_r[i] == CNT_LAST) begin
                cnt_next_s[i]   = CNT_ZERO;
                clean_next_s[i] = sync2_r[i];
                rise_next_s[i]  = sync2_r[i];
                fall_next_s[i]  = ~sync2_r[i];
            end else begin
                cnt_next_s[i] = cnt_r[i] + CNT_ONE;
            end
        end
    end

    // Any channel mid-count keeps the block busy.
    always_comb begin
        busy_s = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (cnt_r[i] != CNT_ZERO) begin
                busy_s = 1'b1;
            end else begin
                busy_s = busy_s;
            end
        end
    end

    // Synchroniser, counters and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_r   <= {WIDTH{1'b0}};
            sync2_r   <= {WIDTH{1'b0}};
            clean_r   <= {WIDTH{1'b0}};
            rise_r    <= {WIDTH{1'b0}};
            fall_r    <= {WIDTH{1'b0}};
            changed_r <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            sync1_r   <= raw;
            sync2_r   <= sync1_r;
            clean_r   <= clean_next_s;
            rise_r    <= rise_next_s;
            fall_r    <= fall_next_s;
            changed_r <= |(rise_next_s | fall_next_s);
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= cnt_next_s[i];
            end
        end
    end

    assign clean   = clean_r;
    assign rise    = rise_r;
    assign fall    = fall_r;
    assign changed = changed_r;
    assign busy    = busy_s;

endmodule
